sd_spi_cmd_xfer: RTL and testbench
==================================

SD_SPI_CMD_XFER -- requirements
Module: sd_spi_cmd_xfer

Interface
REQ-001 Parameter CLK_DIV, default 2: SCK half-period in clk cycles, at least 1.
REQ-002 Parameter RESP_TIMEOUT, default 8: maximum 0xFF poll bytes before a response start byte is found.
REQ-003 Parameter POWERUP_CLKS, default 80: SCK cycles sent with cs_n high before the first command after reset.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 res  in  1  synchronous, active-high reset.
REQ-006 cmd_data  in  48  SD command frame, sent MSB first; bits [45:40] are the command index.
REQ-007 cmd  in  1  single-cycle start strobe.
REQ-008 busy  out  1  transfer in progress.
REQ-009 error  out  1  response timeout flag for the last transfer.
REQ-010 response  out  48  captured response, right-aligned, zero-filled.
REQ-011 sck  out  1  SPI clock, mode 0, idle low.
REQ-012 mosi  out  1  SPI data to card.
REQ-013 miso  in  1  SPI data from card.
REQ-014 cs_n  out  1  card select, active low.

Function
REQ-015 States SHALL be: IDLE, POWERUP, CMD_TX, RESP_WAIT, RESP_RX, TRAIL.
REQ-016 A command SHALL be accepted when cmd=1 and busy=0 in IDLE; cmd_data is latched on that edge.
REQ-017 cmd while busy=1 SHALL be ignored, with no latch and no effect on the transfer in progress.
REQ-018 busy SHALL go high the cycle after acceptance and stay high until the cycle in which response and error are updated.
REQ-019 Acceptance SHALL clear error.
REQ-020 response and error SHALL then hold until the next acceptance.
REQ-021 Routing on acceptance:
  - first command since reset -> POWERUP;
  - otherwise -> CMD_TX.
REQ-022 POWERUP SHALL emit POWERUP_CLKS SCK cycles with cs_n=1 and mosi=1, then go to CMD_TX.
REQ-023 SCK timing SHALL be: low for CLK_DIV clk, then high for CLK_DIV clk, per bit.
  - mosi changes only while sck is low (at the falling edge or the bit start).
  - miso is sampled on the clk edge where sck goes 0->1.
REQ-024 CMD_TX SHALL drive cs_n=0 and shift out all 48 bits MSB first, then go to RESP_WAIT.
REQ-025 RESP_WAIT SHALL clock 0xFF bytes (mosi=1) and sample 8 bits per byte.
  - The first byte with bit7=0 is the start byte -> RESP_RX.
  - If RESP_TIMEOUT bytes pass with none found -> error=1, response=0, then TRAIL.
REQ-026 Response length SHALL be 5 bytes when the latched command index is 8 or 58, otherwise 1 byte.
REQ-027 RESP_RX SHALL clock in the remaining 0 or 4 bytes after the start byte.
  - Storage: response[39:0] for 5-byte responses, response[7:0] for 1-byte responses.
  - Unused upper bits are 0.
REQ-028 response and error SHALL be updated, and busy dropped, on the same clk edge, at the end of TRAIL.
REQ-029 TRAIL SHALL drive cs_n=1 and emit 8 SCK cycles with mosi=1, then go to IDLE.
REQ-030 Between transfers, sck=0, mosi=1 and cs_n=1.
REQ-031 Start-byte search SHALL be byte-aligned to the 8-bit boundaries following the command; there is no bit-level resync.
REQ-032 Counters SHALL saturate or reload per state; no wrap-around shall produce extra SCK edges.

Reset
REQ-033 On res=1 at a clk edge, outputs SHALL be: sck=0, mosi=1, cs_n=1, busy=0, error=0, response=0; state = IDLE.
REQ-034 The powerup-done flag SHALL be cleared by reset, so the next command repeats POWERUP.
REQ-035 Reset mid-transfer SHALL abort immediately, with no trailing SCK cycles.
REQ-036 res SHALL override a cmd strobe asserted in the same cycle.

Verification
REQ-037 CMD0 after reset: cmd_data=0x400000000095; card returns 0xFF then 0x01.
  - Required: 80 SCK with cs_n high, then 48 command bits, then 2 poll bytes, then 8 trail clocks.
  - Final: response=0x000000000001, error=0.
REQ-038 CMD8: cmd_data=0x48000001AA87; card returns 01 00 00 01 AA.
  - Required: no POWERUP (second command).
  - Final: response=0x00_01000001AA, error=0.
REQ-039 CMD0 with miso held at 1.
  - Required: exactly 8 poll bytes, then TRAIL.
  - Final: error=1, response=0, busy falls.
REQ-040 cmd pulsed during CMD_TX with a different cmd_data.
  - Required: the transmitted frame is unchanged, and exactly one busy pulse occurs.
REQ-041 res pulsed at bit 20 of CMD_TX.
  - Required next cycle: cs_n=1, sck=0, busy=0.
  - The following command performs POWERUP again.
REQ-042 CLK_DIV=1 vs CLK_DIV=4 on the CMD0 case.
  - Required SCK period = 2*CLK_DIV clk.
  - mosi is stable across every rising sck.

Source files
------------

// File: rtl/sd_spi_cmd_xfer.sv
// sd_spi_cmd_xfer: SD-card SPI-mode command engine (powerup clocks, 48-bit frame, response poll/capture, trailer)
module sd_spi_cmd_xfer #(
  parameter int CLK_DIV      = 2,
  parameter int RESP_TIMEOUT = 8,
  parameter int POWERUP_CLKS = 80
) (
  input  logic        clk,
  input  logic        res,
  input  logic [47:0] cmd_data,
  input  logic        cmd,
  output logic        busy,
  output logic        error,
  output logic [47:0] response,
  output logic        sck,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);
  typedef enum logic [2:0] {IDLE, POWERUP, CMD_TX, RESP_WAIT, RESP_RX, TRAIL} state_t;
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int CW = $clog2(POWERUP_CLKS > 48 ? POWERUP_CLKS : 48) + 1;
  localparam int BW = $clog2(RESP_TIMEOUT > 4 ? RESP_TIMEOUT : 4) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PU_LAST  = CW'(POWERUP_CLKS - 1);
  localparam logic [BW-1:0] TO_LAST  = BW'(RESP_TIMEOUT - 1);
  state_t state, state_n;
  logic [DW-1:0] div_cnt;
  logic [CW-1:0] cnt;
  logic [BW-1:0] byte_cnt;
  logic [47:0] sh;
  logic [39:0] rx;
  logic ph, pu_done, len5, err_p;
  logic tick, rise, bit_end, byte_st, byte_end;
  assign tick     = div_cnt == DIV_LAST;
  assign rise     = tick && !ph;
  assign bit_end  = tick && ph;
  assign byte_st  = state inside {RESP_WAIT, RESP_RX, TRAIL};
  assign byte_end = bit_end && cnt == CW'(7);
  assign sck      = ph;
  assign mosi     = state == CMD_TX ? sh[47] : 1'b1;
  assign cs_n     = !(state inside {CMD_TX, RESP_WAIT, RESP_RX});
  always_ff @(posedge clk)
    state <= res ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = cmd ? (pu_done ? CMD_TX : POWERUP) : IDLE;
      POWERUP:   if (bit_end && cnt == PU_LAST) state_n = CMD_TX;
      CMD_TX:    if (bit_end && cnt == CW'(47)) state_n = RESP_WAIT;
      RESP_WAIT: if (byte_end) state_n = !rx[7] ? (len5 ? RESP_RX : TRAIL) : (byte_cnt == TO_LAST ? TRAIL : RESP_WAIT);
      RESP_RX:   if (byte_end && byte_cnt == BW'(3)) state_n = TRAIL;
      TRAIL:     if (byte_end) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (res) begin
      div_cnt  <= '0;
      ph       <= 1'b0;
      cnt      <= '0;
      byte_cnt <= '0;
      sh       <= '0;
      rx       <= '0;
      pu_done  <= 1'b0;
      len5     <= 1'b0;
      err_p    <= 1'b0;
      busy     <= 1'b0;
      error    <= 1'b0;
      response <= '0;
    end else begin
      div_cnt  <= (state == IDLE || tick) ? '0 : div_cnt + 1'b1;
      ph       <= state != IDLE && (tick ? !ph : ph);
      cnt      <= (state_n != state || (byte_st && byte_end)) ? '0 : bit_end ? cnt + 1'b1 : cnt;
      byte_cnt <= state_n != state ? '0 : (byte_st && byte_end) ? byte_cnt + 1'b1 : byte_cnt;
      if (rise && (state == RESP_WAIT || state == RESP_RX)) rx <= {rx[38:0], miso};
      if (state == POWERUP && state_n == CMD_TX) pu_done <= 1'b1;
      if (state == CMD_TX && bit_end) sh <= {sh[46:0], 1'b1};
      if (state == RESP_WAIT && state_n == TRAIL && rx[7]) err_p <= 1'b1;
      if (state == IDLE && cmd) begin
        sh    <= cmd_data;
        len5  <= cmd_data[45:40] == 6'd8 || cmd_data[45:40] == 6'd58;
        err_p <= 1'b0;
        busy  <= 1'b1;
        error <= 1'b0;
      end
      // results and busy retire together on the final trailer edge
      if (state == TRAIL && state_n == IDLE) begin
        busy     <= 1'b0;
        error    <= err_p;
        response <= err_p ? '0 : len5 ? {8'h0, rx} : {40'h0, rx[7:0]};
      end
    end
  end
endmodule

// File: tb/tb_sd_spi_cmd_xfer.sv
// tb_sd_spi_cmd_xfer: scoreboard bench with an SPI card model for sd_spi_cmd_xfer
module tb_sd_spi_cmd_xfer;
  localparam int DIV = 3;
  logic clk = 1'b0, res = 1'b1, cmd = 1'b0, miso = 1'b1;
  logic [47:0] cmd_data = '0;
  logic busy, error, sck, mosi, cs_n;
  logic [47:0] response;
  sd_spi_cmd_xfer #(.CLK_DIV(DIV), .RESP_TIMEOUT(8), .POWERUP_CLKS(80)) dut (
    .clk(clk), .res(res), .cmd_data(cmd_data), .cmd(cmd), .busy(busy), .error(error),
    .response(response), .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [47:0] resp;
    logic        err;
    int          pu;
    int          rc;
    logic [47:0] frame;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_pass = 0;
  int rc = 0, pu = 0, tr = 0, nr = 0, pmin = 0, pmax = 0, mbad = 0, brise = 0, cyc = 0, last = 0;
  logic [47:0] frame = '0;
  logic [63:0] card = '0;
  int card_n = 0;
  logic sck_p = 1'b0, busy_p = 1'b0, mosi_r = 1'b1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // card model and bus monitor, sampled mid-cycle away from the DUT's edge
  always @(negedge clk) begin
    cyc++;
    if (cmd && !busy && !res) begin
      rc = 0; pu = 0; tr = 0; nr = 0; pmin = 1 << 30; pmax = 0; mbad = 0; brise = 0; frame = '0;
    end
    if (busy && !busy_p) brise++;
    if (sck && !sck_p) begin
      if (nr > 0) begin
        if (cyc - last < pmin) pmin = cyc - last;
        if (cyc - last > pmax) pmax = cyc - last;
      end
      last = cyc;
      nr++;
      mosi_r = mosi;
      if (cs_n) begin
        if (!mosi) mbad++;
        if (rc == 0) pu++;
        else tr++;
      end else begin
        if (rc < 48) frame = {frame[46:0], mosi};
        rc++;
      end
    end
    if (sck && mosi !== mosi_r) mbad++;
    if (!sck && sck_p) miso = (!cs_n && rc >= 48 && rc - 48 < 8 * card_n) ? card[63 - (rc - 48)] : 1'b1;
    sck_p = sck;
    busy_p = busy;
  end
  task automatic start(input logic [47:0] d, input logic [63:0] cb, input int cn,
                       input logic [47:0] r, input logic e, input int p, input int nrc);
    card = cb;
    card_n = cn;
    sb.push_back('{r, e, p, nrc, d});
    @(posedge clk); #1 cmd_data = d; cmd = 1'b1;
    @(posedge clk); #1 cmd = 1'b0; cmd_data = ~d;
    @(negedge clk);
    chk("busy_rise", busy, 1);
  endtask
  task automatic finish_cmd(input string tag);
    exp_t e;
    int n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, n < 20000, 1);
    e = sb.pop_front();
    chk({tag, "_resp"}, response, e.resp);
    chk({tag, "_err"}, error, e.err);
    chk({tag, "_pu"}, pu, e.pu);
    chk({tag, "_bits"}, rc, e.rc);
    chk({tag, "_trail"}, tr, 8);
    chk({tag, "_frame"}, frame, e.frame);
    chk({tag, "_pmin"}, pmin, 2 * DIV);
    chk({tag, "_pmax"}, pmax, 2 * DIV);
    chk({tag, "_mosi"}, mbad, 0);
    chk({tag, "_busy1"}, brise, 1);
    chk({tag, "_idle"}, {sck, cs_n, mosi}, 3'b011);
  endtask
  task automatic wait_rc(input int k);
    int n = 0;
    while (rc < k && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_bits", n < 5000, 1);
  endtask
  initial begin
    int hi;
    cmd = 1'b1;
    repeat (3) @(posedge clk);
    #1 res = 1'b0; cmd = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_pins", {sck, mosi, cs_n}, 3'b011);
    chk("rst_err", error, 0);
    chk("rst_resp", response, 0);
    start(48'h400000000095, 64'hFF01_0000_0000_0000, 2, 48'h1, 1'b0, 80, 64);
    finish_cmd("cmd0");
    start(48'h48000001AA87, 64'h0100_0001_AA00_0000, 5, 48'h01000001AA, 1'b0, 0, 88);
    finish_cmd("cmd8");
    start(48'h400000000095, 64'h0, 0, 48'h0, 1'b1, 0, 112);
    finish_cmd("tmo");
    start(48'h7A00000000FD, 64'hFFFF_00C0_FF80_0000, 7, 48'h00C0FF8000, 1'b0, 0, 104);
    finish_cmd("cmd58");
    start(48'h770000000065, 64'hFFFF_FFFF_FFFF_FF01, 8, 48'h1, 1'b0, 0, 112);
    finish_cmd("lastpoll");
    start(48'h5100000000FF, 64'hFF05_0000_0000_0000, 2, 48'h5, 1'b0, 0, 64);
    wait_rc(10);
    @(posedge clk); #1 cmd_data = 48'h7A0000000000; cmd = 1'b1;
    @(posedge clk); #1 cmd = 1'b0;
    finish_cmd("ignore");
    start(48'h400000000095, 64'hFF01_0000_0000_0000, 2, 48'h1, 1'b0, 0, 64);
    wait_rc(20);
    @(posedge clk); #1 res = 1'b1;
    @(posedge clk); #1 res = 1'b0;
    @(negedge clk);
    chk("abort_pins", {sck, mosi, cs_n}, 3'b011);
    chk("abort_busy", busy, 0);
    chk("abort_resp", response, 0);
    hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (sck) hi++;
    end
    chk("abort_quiet", hi, 0);
    sb.delete();
    start(48'h400000000095, 64'hFF01_0000_0000_0000, 2, 48'h1, 1'b0, 80, 64);
    finish_cmd("repu");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
